// File: rtl/demux8_sipo_pkg.sv
// Shared constants and types for the 1:8 serial-to-parallel demultiplexer.
//   LANES   : number of lane registers per frame
//   SEL_W   : width of the slot counter
//   state_e : FSM states (PARITY only reachable when DEMUX8_PARITY_EN is defined)
package demux8_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;

endpackage

// File: rtl/demux8_sipo_if.sv
// Bus bundle between a serial beat source and demux8_sipo.
//   din, din_valid, sof          : serial beat stream (master -> slave)
//   dout, dout_valid, sel,
//   frame_err                    : parallel word, strobes and slot index (slave -> master)
// The demux is the slave; the stream source / consumer side is the master.
interface demux8_sipo_if #(
  parameter int unsigned W = 1
);
  import demux8_pkg::*;

  logic [W-1:0]       din;
  logic               din_valid;
  logic               sof;
  logic [LANES*W-1:0] dout;
  logic               dout_valid;
  logic [SEL_W-1:0]   sel;
  logic               frame_err;

  modport master (
    output din, din_valid, sof,
    input  dout, dout_valid, sel, frame_err
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, dout_valid, sel, frame_err
  );

endinterface

// File: rtl/demux8_sipo_dec3x8.sv
// 3-to-8 one-hot write-enable decoder for the shadow lane registers.
//   idx_i : lane index to write
//   en_i  : write enable (beat accepted)
//   we_o  : one-hot lane write enables, all zero when en_i is low
module dec3x8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] we_o
);

  always_comb begin
    we_o = 8'h00;
    if (en_i) begin
      unique case (idx_i)
        3'd0:    we_o = 8'h01;
        3'd1:    we_o = 8'h02;
        3'd2:    we_o = 8'h04;
        3'd3:    we_o = 8'h08;
        3'd4:    we_o = 8'h10;
        3'd5:    we_o = 8'h20;
        3'd6:    we_o = 8'h40;
        default: we_o = 8'h80;
      endcase
    end
  end

endmodule

// File: rtl/demux8_sipo.sv
// Serial-to-parallel 1:8 demultiplexer. Successive accepted beats fill lanes 0..7; when the
// frame completes, the lanes are published on dout with a one-cycle dout_valid strobe.
// sof resynchronizes the slot counter and discards any partial frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux8_sipo_if slave (din/din_valid/sof in, dout/dout_valid/sel/frame_err out)
// Optional feature: define DEMUX8_PARITY_EN to require an even-parity beat after lane 7;
// a mismatch drops the frame and pulses frame_err. Without it frame_err is tied low.
module demux8_sipo
  import demux8_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input logic           clk,
  input logic           rst_n,
  demux8_sipo_if.slave  bus
);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [LANES-1:0][W-1:0] lanes_q, lanes_d;
  logic [LANES*W-1:0]      dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
`ifdef DEMUX8_PARITY_EN
  logic                    frame_err_q, frame_err_d;
`endif

  logic [SEL_W-1:0] wr_idx;
  logic             wr_en;
  logic [LANES-1:0] lane_we;

  // sof forces the beat into lane 0; the parity beat is never stored in a lane.
  assign wr_idx = bus.sof ? '0 : sel_q;
  assign wr_en  = bus.din_valid & (bus.sof | (state_q == COLLECT));

  dec3x8 u_dec3x8 (
    .idx_i (wr_idx),
    .en_i  (wr_en),
    .we_o  (lane_we)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    lanes_d      = lanes_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
`ifdef DEMUX8_PARITY_EN
    frame_err_d  = 1'b0;
`endif

    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) lanes_d[k] = bus.din;
    end

    if (bus.sof) begin
      state_d = COLLECT;
      sel_d   = bus.din_valid ? SEL_W'(1) : '0;
    end else if (bus.din_valid) begin
      unique case (state_q)
        COLLECT: begin
          if (sel_q == SEL_W'(LANES - 1)) begin
            sel_d = '0;
`ifdef DEMUX8_PARITY_EN
            state_d = PARITY;
`else
            // Lane 7 comes straight from din so the word publishes on this edge.
            dout_d       = {bus.din, lanes_q[LANES-2:0]};
            dout_valid_d = 1'b1;
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
`ifdef DEMUX8_PARITY_EN
        PARITY: begin
          state_d = COLLECT;
          sel_d   = '0;
          if (bus.din[0] == (^lanes_q)) begin
            dout_d       = lanes_q;
            dout_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = COLLECT;
          sel_d   = '0;
        end
      endcase
    end
  end

  // Single state register: FSM, counter, shadow lanes and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      sel_q        <= '0;
      lanes_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef DEMUX8_PARITY_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lanes_q      <= lanes_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef DEMUX8_PARITY_EN
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sel        = sel_q;
`ifdef DEMUX8_PARITY_EN
  assign bus.frame_err  = frame_err_q;
`else
  assign bus.frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux8_sipo.sv
module tb_demux8_sipo;

  localparam int unsigned W = 1;
`ifdef DEMUX8_PARITY_EN
  localparam int FRAME_CYC = 9;
`else
  localparam int FRAME_CYC = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux8_sipo_if #(.W(W)) bus ();

  demux8_sipo #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.dout_valid || bus.frame_err)) begin
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual dout=%0h valid=%b err=%b required no strobe",
                 bus.dout, bus.dout_valid, bus.frame_err);
      end else begin
        e = exp_q.pop_front();
        check("strobe_dout", 64'(bus.dout), 64'(e.dout));
        check("strobe_valid", 64'(bus.dout_valid), 64'(!e.err));
        check("strobe_err", 64'(bus.frame_err), 64'(e.err));
      end
    end
  end

  task automatic beat(input logic d, input logic v, input logic s);
    bus.din       = d;
    bus.din_valid = v;
    bus.sof       = s;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0);
  endtask

  // Sends bits v[0..7]; with parity enabled appends the parity beat (good or flipped).
  task automatic send_frame(input logic [7:0] v, input logic bad_par);
    for (int i = 0; i < 8; i++) beat(v[i], 1'b1, 1'b0);
`ifdef DEMUX8_PARITY_EN
    beat((^v) ^ bad_par, 1'b1, 1'b0);
`else
    if (bad_par) $display("note: parity beat ignored in this build");
`endif
  endtask

  logic [7:0] word;
  int         t0;

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("reset_dout", 64'(bus.dout), 64'h0);
    check("reset_dout_valid", 64'(bus.dout_valid), 64'h0);
    check("reset_sel", 64'(bus.sel), 64'h0);
    check("reset_frame_err", 64'(bus.frame_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame: beats 1,0,1,1,0,0,1,0 -> 8'b01001101.
    exp_q.push_back('{dout: 8'h4D, err: 1'b0});
    send_frame(8'h4D, 1'b0);
    check("basic_sel_wrap", 64'(bus.sel), 64'h0);
    idle();
    check("basic_hold", 64'(bus.dout), 64'h4D);
    check("basic_valid_low", 64'(bus.dout_valid), 64'h0);

    // Same frame with a 3-cycle gap after beat 4.
    word = 8'h4D;
    exp_q.push_back('{dout: 8'h4D, err: 1'b0});
    for (int i = 0; i < 4; i++) beat(word[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_sel_hold", 64'(bus.sel), 64'h4);
    end
    for (int i = 4; i < 8; i++) beat(word[i], 1'b1, 1'b0);
`ifdef DEMUX8_PARITY_EN
    beat(^word, 1'b1, 1'b0);
`endif
    idle();

    // sof mid-frame: 5 discarded beats of 1, sof beat 1, then 7 zeros -> 8'h01.
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 1'b0);
    check("pre_sof_sel", 64'(bus.sel), 64'h5);
    exp_q.push_back('{dout: 8'h01, err: 1'b0});
    beat(1'b1, 1'b1, 1'b1);
    check("sof_sel", 64'(bus.sel), 64'h1);
    for (int i = 0; i < 7; i++) beat(1'b0, 1'b1, 1'b0);
`ifdef DEMUX8_PARITY_EN
    beat(1'b1, 1'b1, 1'b0);
`endif
    idle();
    check("sof_dout", 64'(bus.dout), 64'h01);

    // sof without a beat: counter returns to 0, no strobe.
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    check("sof_novalid_sel", 64'(bus.sel), 64'h0);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", 64'(bus.sel), 64'h0);
    check("async_rst_dout", 64'(bus.dout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{dout: 8'h96, err: 1'b0});
    send_frame(8'h96, 1'b0);
    idle();
    check("post_rst_dout", 64'(bus.dout), 64'h96);

    // Back-to-back frames A5 then 3C.
    strobe_cyc.delete();
    t0 = cyc;
    exp_q.push_back('{dout: 8'hA5, err: 1'b0});
    exp_q.push_back('{dout: 8'h3C, err: 1'b0});
    send_frame(8'hA5, 1'b0);
    word = 8'h3C;
    for (int i = 0; i < 4; i++) beat(word[i], 1'b1, 1'b0);
    check("b2b_stable_mid", 64'(bus.dout), 64'hA5);
    for (int i = 4; i < 8; i++) beat(word[i], 1'b1, 1'b0);
`ifdef DEMUX8_PARITY_EN
    beat(^word, 1'b1, 1'b0);
`endif
    idle();
    check("b2b_final_dout", 64'(bus.dout), 64'h3C);
    check("b2b_strobe_count", 64'(strobe_cyc.size()), 64'd2);
    if (strobe_cyc.size() == 2) begin
      check("b2b_first_cycle", 64'(strobe_cyc[0] - t0), 64'(FRAME_CYC));
      check("b2b_spacing", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'(FRAME_CYC));
    end

`ifdef DEMUX8_PARITY_EN
    // Good parity on A5, then bad parity: dout keeps A5, frame_err pulses.
    exp_q.push_back('{dout: 8'hA5, err: 1'b0});
    for (int i = 0; i < 8; i++) begin
      word = 8'hA5;
      beat(word[i], 1'b1, 1'b0);
    end
    check("parity_state_sel", 64'(bus.sel), 64'h0);
    beat(1'b0, 1'b1, 1'b0);
    idle();
    exp_q.push_back('{dout: 8'hA5, err: 1'b1});
    word = 8'h3C;
    send_frame(word, 1'b1);
    idle();
    check("parity_err_hold", 64'(bus.dout), 64'hA5);
    // sof while awaiting parity abandons the frame silently and takes the beat as lane 0.
    for (int i = 0; i < 8; i++) beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    check("parity_sof_sel", 64'(bus.sel), 64'h1);
    exp_q.push_back('{dout: 8'h81, err: 1'b0});
    for (int i = 1; i < 8; i++) beat((i == 7), 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    idle();
    check("parity_sof_dout", 64'(bus.dout), 64'h81);
`endif

    repeat (3) idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
